// File: rtl/ibex_rf_wb_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module  : ibex_rf_wb_arbiter                                               |
// | Brief   : Merges EX results and LSU load data onto the single regfile      |
// |           write port, with a 1-entry skid buffer and read forwarding.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module ibex_rf_wb_arbiter #(
  parameter int unsigned DataWidth         = 32,
  parameter bit          DummyInstructions = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 ex_dummy_i,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_dummy_wb_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 fwd_a_hit_o,
  output logic [DataWidth-1:0] fwd_a_data_o,
  output logic                 fwd_b_hit_o,
  output logic [DataWidth-1:0] fwd_b_data_o,
  output logic                 err_o
);

  localparam logic [4:0] c_x0 = 5'd0;

  logic                 r_skid_valid;
  logic [4:0]           r_skid_waddr;
  logic [DataWidth-1:0] r_skid_wdata;
  logic                 r_skid_dummy;

  logic                 r_rf_we;
  logic [4:0]           r_rf_waddr;
  logic [DataWidth-1:0] r_rf_wdata;
  logic                 r_rf_dummy;

  logic                 r_stall_valid;
  logic [4:0]           r_stall_waddr;
  logic [DataWidth-1:0] r_stall_wdata;
  logic                 r_err;

  logic                 w_ex_acc;
  logic                 w_sel_valid;
  logic [4:0]           w_sel_waddr;
  logic [DataWidth-1:0] w_sel_wdata;
  logic                 w_sel_dummy;
  logic                 w_sel_we;
  logic                 w_sel_tag;
  logic                 w_skid_valid_d;
  logic                 w_skid_load;
  logic                 w_err_d;

  assign ex_ready_o = ~r_skid_valid;
  assign w_ex_acc   = ex_valid_i & ex_ready_o;

  // Source priority: LSU (never stalls), then skid (older EX), then fresh EX.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_waddr = c_x0;
    w_sel_wdata = '0;
    w_sel_dummy = 1'b0;
    if (lsu_valid_i) begin
      w_sel_valid = 1'b1;
      w_sel_waddr = lsu_waddr_i;
      w_sel_wdata = lsu_wdata_i;
    end else if (r_skid_valid) begin
      w_sel_valid = 1'b1;
      w_sel_waddr = r_skid_waddr;
      w_sel_wdata = r_skid_wdata;
      w_sel_dummy = r_skid_dummy;
    end else if (w_ex_acc) begin
      w_sel_valid = 1'b1;
      w_sel_waddr = ex_waddr_i;
      w_sel_wdata = ex_wdata_i;
      w_sel_dummy = ex_dummy_i;
    end
  end

  assign w_sel_tag = DummyInstructions & w_sel_dummy;
  assign w_sel_we  = w_sel_valid & ((w_sel_waddr != c_x0) | w_sel_tag);

  // A younger LSU write to the same register makes the skid entry obsolete.
  always_comb begin
    w_skid_valid_d = r_skid_valid;
    w_skid_load    = 1'b0;
    if (lsu_valid_i) begin
      if (r_skid_valid && (lsu_waddr_i == r_skid_waddr)) begin
        w_skid_valid_d = 1'b0;
      end else if (w_ex_acc) begin
        w_skid_valid_d = 1'b1;
        w_skid_load    = 1'b1;
      end
    end else if (r_skid_valid) begin
      w_skid_valid_d = 1'b0;
    end
  end

  assign w_err_d = r_stall_valid &
                   (~ex_valid_i | (ex_waddr_i != r_stall_waddr) |
                    (ex_wdata_i != r_stall_wdata));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_skid_valid  <= 1'b0;
      r_skid_waddr  <= c_x0;
      r_skid_wdata  <= '0;
      r_skid_dummy  <= 1'b0;
      r_rf_we       <= 1'b0;
      r_rf_waddr    <= c_x0;
      r_rf_wdata    <= '0;
      r_rf_dummy    <= 1'b0;
      r_stall_valid <= 1'b0;
      r_stall_waddr <= c_x0;
      r_stall_wdata <= '0;
      r_err         <= 1'b0;
    end else begin
      r_skid_valid <= w_skid_valid_d;
      if (w_skid_load) begin
        r_skid_waddr <= ex_waddr_i;
        r_skid_wdata <= ex_wdata_i;
        r_skid_dummy <= ex_dummy_i;
      end
      r_rf_we    <= w_sel_we;
      r_rf_dummy <= w_sel_we & w_sel_tag;
      if (w_sel_we) begin
        r_rf_waddr <= w_sel_waddr;
        r_rf_wdata <= w_sel_wdata;
      end
      r_stall_valid <= ex_valid_i & ~ex_ready_o;
      r_stall_waddr <= ex_waddr_i;
      r_stall_wdata <= ex_wdata_i;
      r_err         <= w_err_d;
    end
  end

  assign rf_we_o       = r_rf_we;
  assign rf_waddr_o    = r_rf_waddr;
  assign rf_wdata_o    = r_rf_wdata;
  assign rf_dummy_wb_o = r_rf_dummy;
  assign err_o         = r_err;

  logic w_skid_hit_a, w_skid_hit_b, w_out_hit_a, w_out_hit_b;

  assign w_skid_hit_a = r_skid_valid & ~r_skid_dummy & (raddr_a_i != c_x0) &
                        (r_skid_waddr == raddr_a_i);
  assign w_skid_hit_b = r_skid_valid & ~r_skid_dummy & (raddr_b_i != c_x0) &
                        (r_skid_waddr == raddr_b_i);
  assign w_out_hit_a  = r_rf_we & ~r_rf_dummy & (raddr_a_i != c_x0) &
                        (r_rf_waddr == raddr_a_i);
  assign w_out_hit_b  = r_rf_we & ~r_rf_dummy & (raddr_b_i != c_x0) &
                        (r_rf_waddr == raddr_b_i);

  // Skid holds the younger value, so it wins over the write in flight.
  assign fwd_a_hit_o  = w_skid_hit_a | w_out_hit_a;
  assign fwd_a_data_o = w_skid_hit_a ? r_skid_wdata :
                        w_out_hit_a  ? r_rf_wdata   : '0;
  assign fwd_b_hit_o  = w_skid_hit_b | w_out_hit_b;
  assign fwd_b_data_o = w_skid_hit_b ? r_skid_wdata :
                        w_out_hit_b  ? r_rf_wdata   : '0;

endmodule

`default_nettype wire

// File: tb/tb_ibex_rf_wb_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_ibex_rf_wb_arbiter                                            |
// | Brief   : Directed self-checking bench for ibex_rf_wb_arbiter.             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ibex_rf_wb_arbiter;

  localparam int unsigned DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          ex_valid_i;
  logic          ex_ready_o;
  logic [4:0]    ex_waddr_i;
  logic [DW-1:0] ex_wdata_i;
  logic          ex_dummy_i;
  logic          lsu_valid_i;
  logic [4:0]    lsu_waddr_i;
  logic [DW-1:0] lsu_wdata_i;
  logic          rf_we_o;
  logic [4:0]    rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic          rf_dummy_wb_o;
  logic [4:0]    raddr_a_i;
  logic [4:0]    raddr_b_i;
  logic          fwd_a_hit_o;
  logic [DW-1:0] fwd_a_data_o;
  logic          fwd_b_hit_o;
  logic [DW-1:0] fwd_b_data_o;
  logic          err_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  ibex_rf_wb_arbiter #(
    .DataWidth        (DW),
    .DummyInstructions(1'b1)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .ex_valid_i   (ex_valid_i),
    .ex_ready_o   (ex_ready_o),
    .ex_waddr_i   (ex_waddr_i),
    .ex_wdata_i   (ex_wdata_i),
    .ex_dummy_i   (ex_dummy_i),
    .lsu_valid_i  (lsu_valid_i),
    .lsu_waddr_i  (lsu_waddr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .rf_dummy_wb_o(rf_dummy_wb_o),
    .raddr_a_i    (raddr_a_i),
    .raddr_b_i    (raddr_b_i),
    .fwd_a_hit_o  (fwd_a_hit_o),
    .fwd_a_data_o (fwd_a_data_o),
    .fwd_b_hit_o  (fwd_b_hit_o),
    .fwd_b_data_o (fwd_b_data_o),
    .err_o        (err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] a, input logic [DW-1:0] d, input logic dm);
    ex_valid_i = v; ex_waddr_i = a; ex_wdata_i = d; ex_dummy_i = dm;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] a, input logic [DW-1:0] d);
    lsu_valid_i = v; lsu_waddr_i = a; lsu_wdata_i = d;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [DW-1:0] d);
    chk({tag, "_we"}, rf_we_o, we);
    if (we) begin
      chk({tag, "_waddr"}, rf_waddr_o, a);
      chk({tag, "_wdata"}, rf_wdata_o, d);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    set_ex(0, 0, 0, 0);
    set_lsu(0, 0, 0);
    raddr_a_i = 0;
    raddr_b_i = 0;
    tick();
    tick();
    chk("rst_we", rf_we_o, 0);
    chk("rst_waddr", rf_waddr_o, 0);
    chk("rst_wdata", rf_wdata_o, 0);
    chk("rst_dummy", rf_dummy_wb_o, 0);
    chk("rst_err", err_o, 0);
    rst_ni = 1'b1;
    tick();
    chk("rst_ready", ex_ready_o, 1);

    // EX-only back-to-back stream
    set_ex(1, 1, 32'h11, 0);
    tick(); chk_wr("ex1", 1, 1, 32'h11); chk("ex1_rdy", ex_ready_o, 1);
    set_ex(1, 2, 32'h22, 0);
    tick(); chk_wr("ex2", 1, 2, 32'h22); chk("ex2_rdy", ex_ready_o, 1);
    set_ex(1, 3, 32'h33, 0);
    tick(); chk_wr("ex3", 1, 3, 32'h33); chk("ex3_rdy", ex_ready_o, 1);
    set_ex(0, 0, 0, 0);
    tick(); chk_wr("ex_idle", 0, 0, 0);

    // Same-cycle EX + LSU, forwarding from skid then from output register
    set_ex(1, 5, 32'hA5, 0);
    set_lsu(1, 6, 32'h66);
    raddr_a_i = 5;
    raddr_b_i = 6;
    tick();
    chk_wr("co_lsu", 1, 6, 32'h66);
    chk("co_rdy", ex_ready_o, 0);
    chk("co_fa_hit", fwd_a_hit_o, 1);
    chk("co_fa_data", fwd_a_data_o, 32'hA5);
    chk("co_fb_hit", fwd_b_hit_o, 1);
    chk("co_fb_data", fwd_b_data_o, 32'h66);
    set_ex(0, 0, 0, 0);
    set_lsu(0, 0, 0);
    tick();
    chk_wr("co_ex", 1, 5, 32'hA5);
    chk("co_rdy2", ex_ready_o, 1);
    chk("co_fa_out", fwd_a_data_o, 32'hA5);
    chk("co_fb_miss", fwd_b_hit_o, 0);
    chk("co_fb_zero", fwd_b_data_o, 0);
    tick();
    chk_wr("co_idle", 0, 0, 0);

    // Skid held across two LSU writes
    set_ex(1, 7, 32'h77, 0);
    set_lsu(1, 20, 32'h20);
    tick(); chk_wr("sk_l20", 1, 20, 32'h20);
    set_ex(0, 0, 0, 0);
    set_lsu(1, 8, 32'h88);
    tick(); chk_wr("sk_l8", 1, 8, 32'h88); chk("sk_rdy8", ex_ready_o, 0);
    set_lsu(1, 9, 32'h99);
    tick(); chk_wr("sk_l9", 1, 9, 32'h99); chk("sk_rdy9", ex_ready_o, 0);
    set_lsu(0, 0, 0);
    tick(); chk_wr("sk_x7", 1, 7, 32'h77); chk("sk_rdy", ex_ready_o, 1);

    // Collision: younger LSU write to the skid's register drops the skid
    set_ex(1, 7, 32'h77, 0);
    set_lsu(1, 21, 32'h21);
    raddr_b_i = 7;
    tick(); chk_wr("cl_l21", 1, 21, 32'h21);
    set_ex(0, 0, 0, 0);
    set_lsu(1, 7, 32'hBEEF);
    tick();
    chk_wr("cl_beef", 1, 7, 32'hBEEF);
    chk("cl_rdy", ex_ready_o, 1);
    chk("cl_fb_data", fwd_b_data_o, 32'hBEEF);
    set_lsu(0, 0, 0);
    tick(); chk_wr("cl_drop", 0, 0, 0);

    // x0 filtering and dummy writes
    raddr_a_i = 0;
    set_ex(1, 0, 32'hDEAD, 0);
    tick(); chk_wr("x0_nd", 0, 0, 0);
    set_ex(1, 0, 32'hDEAD, 1);
    tick();
    chk_wr("x0_dm", 1, 0, 32'hDEAD);
    chk("x0_dm_tag", rf_dummy_wb_o, 1);
    chk("x0_fa_hit", fwd_a_hit_o, 0);
    chk("x0_fa_data", fwd_a_data_o, 0);
    set_ex(0, 0, 0, 0);
    tick(); chk("x0_tag_clr", rf_dummy_wb_o, 0);

    // Stalled request withdrawn -> single-cycle error
    set_ex(1, 10, 32'hA0, 0);
    set_lsu(1, 22, 32'h22);
    tick();
    set_ex(1, 11, 32'hB1, 0);
    set_lsu(1, 23, 32'h23);
    tick(); chk("er_none", err_o, 0); chk("er_rdy", ex_ready_o, 0);
    set_ex(0, 0, 0, 0);
    set_lsu(0, 0, 0);
    tick(); chk("er_pulse", err_o, 1); chk_wr("er_x10", 1, 10, 32'hA0);
    tick(); chk("er_clr", err_o, 0);

    // Compliant stall
    set_ex(1, 12, 32'hC0, 0);
    set_lsu(1, 24, 32'h24);
    tick();
    set_ex(1, 13, 32'hD0, 0);
    set_lsu(1, 25, 32'h25);
    tick(); chk("cs_err0", err_o, 0);
    set_lsu(0, 0, 0);
    tick(); chk("cs_err1", err_o, 0); chk_wr("cs_x12", 1, 12, 32'hC0);
    tick(); chk("cs_err2", err_o, 0); chk_wr("cs_x13", 1, 13, 32'hD0);
    set_ex(0, 0, 0, 0);
    tick(); chk_wr("cs_idle", 0, 0, 0);

    // Reset with a full skid loses the buffered write
    set_ex(1, 14, 32'hE0, 0);
    set_lsu(1, 26, 32'h26);
    tick(); chk("mr_rdy_full", ex_ready_o, 0);
    set_ex(0, 0, 0, 0);
    set_lsu(0, 0, 0);
    rst_ni = 1'b0;
    tick();
    chk("mr_we", rf_we_o, 0);
    chk("mr_waddr", rf_waddr_o, 0);
    chk("mr_wdata", rf_wdata_o, 0);
    chk("mr_rdy", ex_ready_o, 1);
    rst_ni = 1'b1;
    tick(); chk("mr_we2", rf_we_o, 0);
    tick(); chk("mr_we3", rf_we_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
